// File: rtl/ldpc_hard_decision_out.sv
// ---------------------------------------------------------------------------
// ldpc_hard_decision_out
//   Output end of the LDPC decoder. Captures the final posterior LLR vector
//   (unsigned Q5.10 magnitude plus a separate sign bit) together with the
//   original noisy key, makes the hard decision per bit and streams the
//   corrected key out in OUT_W-bit beats. After the last beat it publishes
//   the number of flipped bits and of low-confidence bits.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a block is present on x_i / llr_mag / llr_sign
//   in_ready   out  the block can be accepted (IDLE)
//   x_i        in   N   original noisy sifted key
//   llr_mag    in   N*LLR_W posterior magnitudes, bit i at [i*LLR_W +: LLR_W]
//   llr_sign   in   N   posterior signs, 1 = negative LLR
//   out_valid  out  out_data holds a beat
//   out_ready  in   downstream accepts the beat
//   out_data   out  OUT_W corrected key bits, beat k = bits [k*OUT_W +: OUT_W]
//   out_last   out  final beat of the block
//   err_count  out  7   bits flipped relative to x_i in the last block
//   low_count  out  7   low-confidence bits in the last block
//   done       out  one-cycle pulse when err_count/low_count update
// ---------------------------------------------------------------------------
module ldpc_hard_decision_out #(
  parameter int               N          = 100,
  parameter int               LLR_W      = 15,
  parameter int               OUT_W      = 10,
  parameter logic [LLR_W-1:0] LOWCONF_TH = 15'd512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         x_i,
  input  logic [N*LLR_W-1:0]   llr_mag,
  input  logic [N-1:0]         llr_sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_last,
  output logic [6:0]           err_count,
  output logic [6:0]           low_count,
  output logic                 done
);

  localparam int NB = N / OUT_W;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_r, state_nxt;
  logic [N-1:0]       x_r, sign_r;
  logic [N*LLR_W-1:0] mag_r;
  logic [BW-1:0]      beat_cnt_r;
  logic [6:0]         flip_acc_r, low_acc_r, err_count_r, low_count_r;
  logic               done_r;

  logic [N-1:0]       dec_s, flip_s, low_s;
  logic [OUT_W-1:0]   beat_dec_s, beat_flip_s, beat_low_s;
  logic [6:0]         beat_flip_cnt_s, beat_low_cnt_s;
  logic               last_beat_s, accept_s, beat_hs_s;

  // Population count of one beat; result fits in 7 bits for any OUT_W <= N.
  function automatic logic [6:0] popcount(input logic [OUT_W-1:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < OUT_W; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  // Per-bit hard decision from captured state; a zero magnitude keeps the channel bit.
  always_comb begin
    dec_s  = '0;
    flip_s = '0;
    low_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (mag_r[i*LLR_W +: LLR_W] != {LLR_W{1'b0}}) begin
        dec_s[i] = sign_r[i];
      end else begin
        dec_s[i] = x_r[i];
      end
      flip_s[i] = dec_s[i] ^ x_r[i];
      low_s[i]  = (mag_r[i*LLR_W +: LLR_W] < LOWCONF_TH);
    end
  end

  // Select the current beat and count its flips and low-confidence bits.
  always_comb begin
    beat_dec_s      = dec_s[int'(beat_cnt_r)*OUT_W +: OUT_W];
    beat_flip_s     = flip_s[int'(beat_cnt_r)*OUT_W +: OUT_W];
    beat_low_s      = low_s[int'(beat_cnt_r)*OUT_W +: OUT_W];
    beat_flip_cnt_s = popcount(beat_flip_s);
    beat_low_cnt_s  = popcount(beat_low_s);
    last_beat_s     = (beat_cnt_r == BW'(NB - 1));
  end

  // Next-state logic and handshake outputs decoded from the state register.
  always_comb begin
    state_nxt = state_r;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && last_beat_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SEND;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept_s  = in_valid && in_ready;
  assign beat_hs_s = out_valid && out_ready;

  // Beat payload is forced to zero outside SEND so stale decisions never leak.
  always_comb begin
    if (state_r == SEND) begin
      out_data = beat_dec_s;
      out_last = last_beat_s;
    end else begin
      out_data = '0;
      out_last = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Capture, beat counting, accumulation and count publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= '0;
      sign_r      <= '0;
      mag_r       <= '0;
      beat_cnt_r  <= '0;
      flip_acc_r  <= 7'd0;
      low_acc_r   <= 7'd0;
      err_count_r <= 7'd0;
      low_count_r <= 7'd0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        x_r        <= x_i;
        sign_r     <= llr_sign;
        mag_r      <= llr_mag;
        beat_cnt_r <= '0;
        flip_acc_r <= 7'd0;
        low_acc_r  <= 7'd0;
      end else if (beat_hs_s) begin
        flip_acc_r <= flip_acc_r + beat_flip_cnt_s;
        low_acc_r  <= low_acc_r + beat_low_cnt_s;
        beat_cnt_r <= beat_cnt_r + BW'(1);
        if (last_beat_s) begin
          err_count_r <= flip_acc_r + beat_flip_cnt_s;
          low_count_r <= low_acc_r + beat_low_cnt_s;
          done_r      <= 1'b1;
        end else begin
          done_r <= 1'b0;
        end
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  assign err_count = err_count_r;
  assign low_count = low_count_r;
  assign done      = done_r;

endmodule

// File: tb/tb_ldpc_hard_decision_out.sv
// ---------------------------------------------------------------------------
// tb_ldpc_hard_decision_out
//   Directed self-checking bench for ldpc_hard_decision_out. Inputs are
//   driven and outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_ldpc_hard_decision_out;

  localparam int N     = 100;
  localparam int LLR_W = 15;
  localparam int OUT_W = 10;
  localparam int NB    = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N-1:0]       x_i = '0;
  logic [N*LLR_W-1:0] llr_mag = '0;
  logic [N-1:0]       llr_sign = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [OUT_W-1:0]   out_data;
  logic               out_last;
  logic [6:0]         err_count;
  logic [6:0]         low_count;
  logic               done;

  int checks = 0;
  int failures = 0;

  ldpc_hard_decision_out dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .llr_mag(llr_mag), .llr_sign(llr_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .err_count(err_count), .low_count(low_count), .done(done)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Magnitude vector with every bit set to the same value.
  function automatic logic [N*LLR_W-1:0] mag_all(input logic [LLR_W-1:0] v);
    logic [N*LLR_W-1:0] m;
    for (int i = 0; i < N; i++) m[i*LLR_W +: LLR_W] = v;
    return m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 10'h000) begin
      failures++;
      $display("FAIL reset_handshake got in_ready=%0b out_valid=%0b out_last=%0b out_data=%h, expected 1 0 0 000",
               in_ready, out_valid, out_last, out_data);
    end
    checks++;
    if (err_count !== 7'd0 || low_count !== 7'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_counts got err=%0d low=%0d done=%0b, expected 0 0 0", err_count, low_count, done);
    end
  endtask

  task automatic test_no_errors();
    x_i = '0; llr_sign = '0; llr_mag = mag_all(15'h0400);
    out_ready = 1'b1; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL noerr_accept got in_ready=%0b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 10'h000 || out_last !== 1'(k == NB-1) || done !== 1'b0) begin
        failures++;
        $display("FAIL noerr_beat%0d got valid=%0b data=%h last=%0b done=%0b, expected 1 000 %0b 0",
                 k, out_valid, out_data, out_last, done, (k == NB-1));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || err_count !== 7'd0 || low_count !== 7'd0) begin
      failures++;
      $display("FAIL noerr_done got done=%0b in_ready=%0b out_valid=%0b err=%0d low=%0d, expected 1 1 0 0 0",
               done, in_ready, out_valid, err_count, low_count);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL noerr_done_pulse got done=%0b expected 0", done);
    end
  endtask

  task automatic test_flips();
    logic [N-1:0] exp_key;
    exp_key = '0;
    exp_key[0] = 1'b1; exp_key[9] = 1'b1; exp_key[10] = 1'b1; exp_key[99] = 1'b1;
    x_i = '0; llr_sign = exp_key; llr_mag = mag_all(15'h0400);
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_key[k*OUT_W +: OUT_W] || out_last !== 1'(k == NB-1)) begin
        failures++;
        $display("FAIL flips_beat%0d got valid=%0b data=%h last=%0b, expected 1 %h %0b",
                 k, out_valid, out_data, out_last, exp_key[k*OUT_W +: OUT_W], (k == NB-1));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || err_count !== 7'd4 || low_count !== 7'd0) begin
      failures++;
      $display("FAIL flips_counts got done=%0b err=%0d low=%0d, expected 1 4 0", done, err_count, low_count);
    end
    step();
  endtask

  task automatic test_tie_lowconf();
    logic [N-1:0] exp_key;
    exp_key = '0; exp_key[5] = 1'b1;
    x_i = '0; x_i[5] = 1'b1; llr_sign = '0;
    llr_mag = mag_all(15'h0400);
    llr_mag[5*LLR_W +: LLR_W] = 15'd0;
    llr_mag[6*LLR_W +: LLR_W] = 15'd511;
    llr_mag[7*LLR_W +: LLR_W] = 15'd512;
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_key[k*OUT_W +: OUT_W] || out_last !== 1'(k == NB-1)) begin
        failures++;
        $display("FAIL tie_beat%0d got valid=%0b data=%h last=%0b, expected 1 %h %0b",
                 k, out_valid, out_data, out_last, exp_key[k*OUT_W +: OUT_W], (k == NB-1));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || err_count !== 7'd0 || low_count !== 7'd2) begin
      failures++;
      $display("FAIL tie_counts got done=%0b err=%0d low=%0d, expected 1 0 2", done, err_count, low_count);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [N-1:0]     exp_key;
    logic [3:0]       pattern;
    logic             prev_stall;
    logic [OUT_W-1:0] prev_data;
    logic             prev_last;
    int               seen;
    pattern = 4'b1001;   // out_ready per cycle: 1,0,0,1 (bit 0 first)
    exp_key = '0;
    exp_key[3] = 1'b1; exp_key[27] = 1'b1; exp_key[50] = 1'b1;
    exp_key[51] = 1'b1; exp_key[88] = 1'b1;
    x_i = '0; llr_sign = exp_key; llr_mag = mag_all(15'h0100);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    // Present a different block while streaming; it must not be accepted.
    x_i = '1; llr_sign = '0;
    seen = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 80 && seen < NB; cyc++) begin
      out_ready = pattern[cyc % 4];
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_send_state cyc=%0d got in_ready=%0b out_valid=%0b, expected 0 1", cyc, in_ready, out_valid);
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_data || out_last !== prev_last) begin
          failures++;
          $display("FAIL bp_stable cyc=%0d got data=%h last=%0b, expected %h %0b",
                   cyc, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_ready) begin
        checks++;
        if (out_data !== exp_key[seen*OUT_W +: OUT_W] || out_last !== 1'(seen == NB-1)) begin
          failures++;
          $display("FAIL bp_beat%0d got data=%h last=%0b, expected %h %0b",
                   seen, out_data, out_last, exp_key[seen*OUT_W +: OUT_W], (seen == NB-1));
        end
        seen++;
        if (seen == NB) in_valid = 1'b0;
      end
      prev_stall = !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (seen != NB) begin
      failures++; $display("FAIL bp_timeout got beats=%0d expected %0d", seen, NB);
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || err_count !== 7'd5 || low_count !== 7'd100) begin
      failures++;
      $display("FAIL bp_counts got done=%0b out_valid=%0b err=%0d low=%0d, expected 1 0 5 100",
               done, out_valid, err_count, low_count);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_extra got out_valid=%0b in_ready=%0b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_block();
    logic [N-1:0] exp_key;
    x_i = '0; llr_sign = '0; llr_sign[60] = 1'b1; llr_mag = mag_all(15'h0400);
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();   // beats 0..4 accepted
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || err_count !== 7'd0 || low_count !== 7'd0) begin
      failures++;
      $display("FAIL rstmid_drop got out_valid=%0b done=%0b err=%0d low=%0d, expected 0 0 0 0",
               out_valid, done, err_count, low_count);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle got done=%0b in_ready=%0b out_valid=%0b, expected 0 1 0", done, in_ready, out_valid);
    end
    // New block: x differs from the decision at bits 2 and 41, bit 70 is low-confidence.
    exp_key = '0; exp_key[2] = 1'b1; exp_key[70] = 1'b1;
    x_i = '0; x_i[41] = 1'b1; x_i[70] = 1'b1;
    llr_sign = '0; llr_sign[2] = 1'b1;
    llr_mag = mag_all(15'h0400);
    llr_mag[70*LLR_W +: LLR_W] = 15'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_key[k*OUT_W +: OUT_W] || out_last !== 1'(k == NB-1)) begin
        failures++;
        $display("FAIL rstmid_beat%0d got valid=%0b data=%h last=%0b, expected 1 %h %0b",
                 k, out_valid, out_data, out_last, exp_key[k*OUT_W +: OUT_W], (k == NB-1));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || err_count !== 7'd2 || low_count !== 7'd1) begin
      failures++;
      $display("FAIL rstmid_counts got done=%0b err=%0d low=%0d, expected 1 2 1", done, err_count, low_count);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_no_errors();
    test_flips();
    test_tie_lowconf();
    test_backpressure();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
